// File: rtl/router_pkg.sv
// Shared router types: flit layout and head-field accessors, node coordinates,
// and the ejection checker state encoding.
package router_pkg;

   localparam int COORD_W   = 4;
   localparam int FLIT_DATA = 30;

   typedef enum logic [1:0] {
      HEAD      = 2'b00,
      BODY      = 2'b01,
      TAIL      = 2'b10,
      HEAD_TAIL = 2'b11
   } flit_type_t;

   // Head flits carry {dst_x, dst_y} in the top of data; other flits use it as payload.
   typedef struct packed {
      flit_type_t             flit_type;
      logic [FLIT_DATA-1:0]   data;
   } FLIT_t;

   typedef struct packed {
      logic [COORD_W-1:0] xaddr;
      logic [COORD_W-1:0] yaddr;
   } router_conf_t;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } sink_state_t;

   function automatic logic [COORD_W-1:0] dst_x(input FLIT_t f);
      return f.data[FLIT_DATA-1 -: COORD_W];
   endfunction

   function automatic logic [COORD_W-1:0] dst_y(input FLIT_t f);
      return f.data[FLIT_DATA-1-COORD_W -: COORD_W];
   endfunction

endpackage

// File: rtl/sink_fifo.sv
// Small synchronous FIFO; callers only assert push/pop when they are legal.
// Read data is the head entry, visible combinationally so it can be consumed on the pop edge.
module sink_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign count   = count_reg;
   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);

endmodule

// File: rtl/local_sink.sv
// LOCAL-port ejection endpoint: buffers router flits under on/off flow control,
// checks packet framing and destination on pop, and keeps saturating counters.
module local_sink
   import router_pkg::*;
#(
   parameter router_conf_t router_conf = '{xaddr: 4'd0, yaddr: 4'd0},
   parameter int           FIFO_DEPTH  = 4,
   parameter int           OFF_SLACK   = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  FLIT_t       i_flit,
   input  logic        i_upstream_req,
   input  logic        i_drain_en,
   output logic        o_on_off,
   output logic [31:0] o_pkt_count,
   output logic [31:0] o_flit_count,
   output logic        o_err_dest,
   output logic        o_err_proto,
   output logic        o_err_ovf,
   output logic        o_busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_next;
   FLIT_t         head_flit;
   logic          push_fire;
   logic          pop_fire;
   logic          ovf_hit;

   // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
   assign pop_fire  = i_drain_en && !fifo_empty;
   assign push_fire = i_upstream_req && (!fifo_full || pop_fire);
   assign ovf_hit   = i_upstream_req && fifo_full && !pop_fire;

   sink_fifo #(
      .WIDTH ($bits(FLIT_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_fire),
      .pop     (pop_fire),
      .wr_data (i_flit),
      .rd_data (head_flit),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      count_next = fifo_count;
      case ({push_fire, pop_fire})
         2'b10:   count_next = fifo_count + 1'b1;
         2'b01:   count_next = fifo_count - 1'b1;
         default: count_next = fifo_count;
      endcase
   end

   // Checker FSM
   sink_state_t state_reg;
   sink_state_t state_next;
   logic        bad_reg;
   logic        bad_next;
   logic        pkt_done;
   logic        proto_hit;
   logic        dest_hit;
   logic        dest_ok;

   assign dest_ok = (dst_x(head_flit) == router_conf.xaddr) &&
                    (dst_y(head_flit) == router_conf.yaddr);

   always_comb begin
      state_next = state_reg;
      bad_next   = bad_reg;
      pkt_done   = 1'b0;
      proto_hit  = 1'b0;
      dest_hit   = 1'b0;
      if (pop_fire) begin
         case (head_flit.flit_type)
            HEAD: begin
               // A head inside a packet aborts the old one and starts afresh.
               proto_hit  = (state_reg == IN_PKT);
               state_next = IN_PKT;
               bad_next   = !dest_ok;
               dest_hit   = !dest_ok;
            end
            HEAD_TAIL: begin
               proto_hit  = (state_reg == IN_PKT);
               state_next = IDLE;
               bad_next   = 1'b0;
               dest_hit   = !dest_ok;
               pkt_done   = dest_ok;
            end
            BODY: begin
               proto_hit = (state_reg == IDLE);
            end
            TAIL: begin
               if (state_reg == IDLE) begin
                  proto_hit = 1'b1;
               end else begin
                  state_next = IDLE;
                  pkt_done   = !bad_reg;
                  bad_next   = 1'b0;
               end
            end
            default: begin
               state_next = state_reg;
            end
         endcase
      end
   end

   logic [31:0] pkt_count_reg;
   logic [31:0] flit_count_reg;
   logic        err_dest_reg;
   logic        err_proto_reg;
   logic        err_ovf_reg;
   logic        on_off_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         bad_reg        <= 1'b0;
         pkt_count_reg  <= '0;
         flit_count_reg <= '0;
         err_dest_reg   <= 1'b0;
         err_proto_reg  <= 1'b0;
         err_ovf_reg    <= 1'b0;
         on_off_reg     <= 1'b1;
      end else begin
         state_reg  <= state_next;
         bad_reg    <= bad_next;
         on_off_reg <= (count_next < CW'(FIFO_DEPTH - OFF_SLACK));
         if (pkt_done && (pkt_count_reg != '1)) begin
            pkt_count_reg <= pkt_count_reg + 1'b1;
         end
         if (pop_fire && (flit_count_reg != '1)) begin
            flit_count_reg <= flit_count_reg + 1'b1;
         end
         if (dest_hit) begin
            err_dest_reg <= 1'b1;
         end
         if (proto_hit) begin
            err_proto_reg <= 1'b1;
         end
         if (ovf_hit) begin
            err_ovf_reg <= 1'b1;
         end
      end
   end

   assign o_on_off     = on_off_reg;
   assign o_pkt_count  = pkt_count_reg;
   assign o_flit_count = flit_count_reg;
   assign o_err_dest   = err_dest_reg;
   assign o_err_proto  = err_proto_reg;
   assign o_err_ovf    = err_ovf_reg;
   assign o_busy       = !fifo_empty || (state_reg == IN_PKT);

   // Payload bits are not inspected by the checker.
   logic unused_payload;
   assign unused_payload = ^head_flit.data[FLIT_DATA-1-2*COORD_W:0];

endmodule

// File: doc/local_sink.md
# local_sink

Ejection endpoint for the LOCAL output port of a mesh router. It accepts flits pushed by the router's LOCAL output under on/off flow control and buffers them in a small FIFO. It drains the FIFO into a packet checker that validates head/body/tail framing and destination address, and maintains packet, flit and error counters. Each mesh node instantiates one sink next to its traffic generator, closing the injection/ejection loop.

## Interface
Parameters:
- router_conf, '{xaddr:0, yaddr:0}: coordinates of the owning node; head flits must carry these as destination.
- FIFO_DEPTH, 4: ingress buffer entries; power of two, ≥4.
- OFF_SLACK, 2: free entries reserved for in-flight flits when o_on_off drops.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_flit  in  FLIT_t  flit from router LOCAL output.
- i_upstream_req  in  1  i_flit valid this cycle.
- i_drain_en  in  1  consumer ready; pop one flit per cycle when high.
- o_on_off  out  1  1 = router may send; wired to router i_downstream_ack[LOCAL_PORT].
- o_pkt_count  out  32  completed, error-free packets.
- o_flit_count  out  32  flits popped.
- o_err_dest  out  1  sticky: head destination ≠ router_conf.
- o_err_proto  out  1  sticky: framing violation.
- o_err_ovf  out  1  sticky: push while full without pop.
- o_busy  out  1  FIFO non-empty or checker in IN_PKT.

## Operation
- Push: i_upstream_req=1 writes i_flit at the posedge. A push is accepted if occupancy < FIFO_DEPTH, or if a pop happens in the same cycle. Otherwise the flit is dropped and o_err_ovf is set.
- Pop: when i_drain_en=1 and the FIFO is non-empty, the oldest flit goes to the checker. o_flit_count increments.
- Flow control: o_on_off is registered and equals 1 when next-cycle occupancy < FIFO_DEPTH − OFF_SLACK.
- Checker FSM has two states, IDLE and IN_PKT. The flit_type codes are HEAD, BODY, TAIL and HEAD_TAIL.
  - IDLE + HEAD → IN_PKT; IDLE + HEAD_TAIL → IDLE, packet complete.
  - IDLE + BODY/TAIL → o_err_proto, flit discarded, stay IDLE.
  - IN_PKT + BODY → stay; IN_PKT + TAIL → IDLE, packet complete.
  - IN_PKT + HEAD/HEAD_TAIL → o_err_proto, the current packet is aborted and not counted, and the new head is processed as if in IDLE.
  - Head dst_x/dst_y ≠ router_conf → o_err_dest, and the packet is marked bad. A bad packet completes without incrementing o_pkt_count.
- Counters saturate at 2^32−1. Sticky errors clear only on reset.

## Timing
- Reset (async assert, sync deassert by system): FIFO empty, FSM IDLE, counters 0, errors 0, o_busy=0, o_on_off=1.
- Push-to-pop latency is 1 cycle minimum: a flit written at edge N is poppable at edge N+1.
- Checker results (counters, errors, FSM) update at the same edge as the pop.
- o_on_off reflects occupancy after edge N starting at edge N. With OFF_SLACK=2, one in-flight flit plus one reaction cycle never overflows.
- Simultaneous push and pop on a full FIFO: both are accepted and occupancy is unchanged. On an empty FIFO, a push and pop in the same cycle do not bypass; the pop is ignored.
- Pointers wrap modulo FIFO_DEPTH. A separate occupancy counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- Reset mid-packet discards FIFO contents and any partial packet. No error is flagged.

## Structure
- Add to router_pkg: the flit_type enum (HEAD, BODY, TAIL, HEAD_TAIL) and the dst_x/dst_y head-field accessors shared with TrafficGenerator.
- Add to router_pkg: the sink_state_t enum (IDLE, IN_PKT).
- One sub-module, sink_fifo: parameterised synchronous FIFO with push, pop, full, empty and count. The checker FSM and counters live in local_sink.

## Test plan
- Send HEAD, BODY, BODY, TAIL addressed to (1,2) with router_conf (1,2) and i_drain_en=1 → o_pkt_count=1, o_flit_count=4, all errors 0, o_busy=0 afterwards.
- Hold i_drain_en=0 and push while honouring o_on_off (DEPTH 4, SLACK 2) → o_on_off drops after the 2nd push, at most 3 flits are stored, o_err_ovf=0. Then set i_drain_en=1 → o_on_off returns to 1 within 1 cycle after occupancy < 2.
- Ignore o_on_off and push 5 flits with drain off → the 5th is dropped, o_err_ovf=1, FIFO holds 4 flits.
- Send HEAD_TAIL to (0,0) at sink (1,2) → o_err_dest=1, o_pkt_count=0, o_flit_count=1.
- Send HEAD, HEAD, TAIL → o_err_proto=1, o_pkt_count=1 (second packet only). Send a lone BODY → stays IDLE, no count change.
- Assert reset_n=0 mid-packet with 3 flits buffered → outputs immediately at reset values. After release, a fresh 2-flit packet gives o_pkt_count=1.
